pipe_stage_reg: RTL and testbench

- Parametrised pipeline-stage register; successor to the fixed-width IF/ID latch.
- Carries an arbitrary payload (e.g. {pc, pc_4, instr}) between any two CPU stages.
- Uses a valid/ready handshake, a flush input, and an optional 2-entry skid buffer so upstream ready is registered.
- Sits between IF/ID, ID/EX, EX/MEM and MEM/WB, replacing the per-stage hand-written latches.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_stage_reg.sv | 146 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the generic CPU pipeline-stage register:
//   - stage occupancy state encodings (also used directly as the occupancy
//     count: EMPTY=0, ONE=1, FULL=2)
//   - payload widths of the four inter-stage registers
// ---------------------------------------------------------------------------
package pipe_pkg;

    typedef logic [1:0] stage_state_t;

    localparam stage_state_t ST_EMPTY = 2'd0;
    localparam stage_state_t ST_ONE   = 2'd1;
    localparam stage_state_t ST_FULL  = 2'd2;

    // IF/ID : {pc, instr}
    localparam int unsigned IF_ID_W  = 64;
    // ID/EX : {pc, rs1_val, rs2_val, imm, ctrl}
    localparam int unsigned ID_EX_W  = 160;
    // EX/MEM: {alu_res, store_data, rd, ctrl}
    localparam int unsigned EX_MEM_W = 80;
    // MEM/WB: {wb_data, rd, ctrl}
    localparam int unsigned MEM_WB_W = 48;

endpackage : pipe_pkg

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Parametrised valid/ready pipeline-stage register placed between CPU stages.
// SKID=1 : output register plus one overflow (skid) register; in_ready is
//          registered, so there is no out_ready -> in_ready combinational path.
// SKID=0 : single register; in_ready = ~out_valid | out_ready.
// Both modes give 1-cycle latency and 1 beat/cycle with out_ready held high.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset (also acts as a flush)
//   flush      drops all held beats and any beat offered this cycle
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream payload [DATA_W]
//   out_valid  downstream beat valid
//   out_ready  downstream accepts the beat (0 = stall)
//   out_data   payload to the next stage [DATA_W]
//   occupancy  number of beats held (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W       = IF_ID_W,
    parameter bit          SKID         = 1'b1,
    parameter bit          CLR_ON_EMPTY = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    stage_state_t      state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
    logic              push;
    logic              pop;

    assign out_valid = (state_q != ST_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign occupancy = state_q;
    // Zero-bubble convention: an empty stage presents an all-zero payload.
    assign out_data  = (CLR_ON_EMPTY && !out_valid) ? '0 : main_q;

    generate
        if (SKID) begin : g_skid
            logic [DATA_W-1:0] skid_q, skid_d;
            logic              in_ready_q;

            // Reset forces in_ready low during the reset cycle itself; the
            // register already holds 1 so it is high on the first free cycle.
            assign in_ready = in_ready_q & ~reset;

            // NOTE: every signal assigned in an always_comb gets a default
            // first, otherwise uncovered paths infer latches.
            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                case (state_q)
                    ST_EMPTY: begin
                        if (push) begin
                            state_d = ST_ONE;
                            main_d  = in_data;
                        end
                    end
                    ST_ONE: begin
                        if (push && !pop) begin
                            state_d = ST_FULL;
                            skid_d  = in_data;
                        end else if (pop && !push) begin
                            state_d = ST_EMPTY;
                            if (CLR_ON_EMPTY) main_d = '0;
                        end else if (push && pop) begin
                            main_d  = in_data;
                        end
                    end
                    ST_FULL: begin
                        // in_ready is low here, so only a pop can happen.
                        if (pop) begin
                            state_d = ST_ONE;
                            main_d  = skid_q;
                        end
                    end
                    default: begin
                        state_d = ST_EMPTY;
                        main_d  = '0;
                    end
                endcase
                if (flush) begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                end
            end

            // NOTE: the skid register is pure data qualified by state_q, so
            // it is deliberately left out of reset.
            always_ff @(posedge clk) begin
                skid_q <= skid_d;
                if (reset) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != ST_FULL);
                end
            end
        end else begin : g_noskid
            assign in_ready = (~out_valid | out_ready) & ~reset;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                if (push) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                    if (CLR_ON_EMPTY) main_d = '0;
                end
                if (flush) begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                end
            end
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
// Drives one SKID=1 and one SKID=0 instance side by side. Each instance has a
// queue scoreboard: accepted beats are pushed when driven and popped when the
// model says the DUT delivers them; outputs are compared every cycle.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;

    logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [W-1:0] s_in_data, s_out_data;
    logic [1:0]   s_occ;

    logic         n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [W-1:0] n_in_data, n_out_data;
    logic [1:0]   n_occ;

    logic [W-1:0] q_s[$];
    logic [W-1:0] q_n[$];
    logic         s_last_push, n_last_push;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(W), .SKID(1'b1), .CLR_ON_EMPTY(1'b1)) dut_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .occupancy (s_occ)
    );

    pipe_stage_reg #(.DATA_W(W), .SKID(1'b0), .CLR_ON_EMPTY(1'b1)) dut_noskid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_data   (n_in_data),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_data  (n_out_data),
        .occupancy (n_occ)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs against the models at the falling
    // edge, update the models with this cycle's handshakes, then advance to
    // just after the rising edge where the caller drives the next inputs.
    task automatic step();
        logic         exp_rdy_s, exp_rdy_n;
        logic         push_s, pop_s, push_n, pop_n;
        logic [W-1:0] exp_d_s, exp_d_n;

        @(negedge clk);
        exp_rdy_s = !reset && (q_s.size() != 2);
        exp_rdy_n = !reset && ((q_n.size() == 0) || n_out_ready);
        exp_d_s   = (q_s.size() != 0) ? q_s[0] : '0;
        exp_d_n   = (q_n.size() != 0) ? q_n[0] : '0;

        check("s_valid", 32'(s_out_valid), 32'(q_s.size() != 0));
        check("s_data",  32'(s_out_data),  32'(exp_d_s));
        check("s_occ",   32'(s_occ),       32'(q_s.size()));
        check("s_ready", 32'(s_in_ready),  32'(exp_rdy_s));
        check("n_valid", 32'(n_out_valid), 32'(q_n.size() != 0));
        check("n_data",  32'(n_out_data),  32'(exp_d_n));
        check("n_occ",   32'(n_occ),       32'(q_n.size()));
        check("n_ready", 32'(n_in_ready),  32'(exp_rdy_n));

        push_s = s_in_valid && exp_rdy_s;
        pop_s  = (q_s.size() != 0) && s_out_ready;
        push_n = n_in_valid && exp_rdy_n;
        pop_n  = (q_n.size() != 0) && n_out_ready;
        s_last_push = push_s;
        n_last_push = push_n;

        if (reset || flush) begin
            q_s.delete();
            q_n.delete();
        end else begin
            if (pop_s)  void'(q_s.pop_front());
            if (push_s) q_s.push_back(s_in_data);
            if (pop_n)  void'(q_n.pop_front());
            if (push_n) q_n.push_back(n_in_data);
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 16'h0011;
        s_out_ready = 1'b0;
        n_in_valid  = 1'b1;
        n_in_data   = 16'h0011;
        n_out_ready = 1'b0;
        s_last_push = 1'b0;
        n_last_push = 1'b0;

        // Reset: two cycles with a beat offered; nothing may be accepted.
        @(posedge clk);
        #1;
        step();
        step();
        check("rst_valid", 32'(s_out_valid), 32'd0);
        check("rst_data",  32'(s_out_data),  32'd0);
        check("rst_occ",   32'(s_occ),       32'd0);
        check("rst_ready_during", 32'(s_in_ready), 32'd0);
        reset      = 1'b0;
        s_in_valid = 1'b0;
        n_in_valid = 1'b0;
        #1;
        check("rst_ready_after", 32'(s_in_ready), 32'd1);
        check("rst_ready_after_n", 32'(n_in_ready), 32'd1);

        // Streaming through the skid variant.
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_in_data = 16'h00A0 + 16'(i);
            step();
            check("stream_data",  32'(s_out_data), 32'h00A0 + 32'(i));
            check("stream_ready", 32'(s_in_ready), 32'd1);
            check("stream_occ",   32'(s_occ),      32'd1);
        end
        s_in_valid = 1'b0;
        step();
        check("stream_drain", 32'(s_out_valid), 32'd0);

        // Backpressure fills the skid register, then drains in order.
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 16'h00B0;
        step();
        s_in_data   = 16'h00B1;
        step();
        s_in_valid  = 1'b0;
        check("bp_occ",   32'(s_occ),      32'd2);
        check("bp_ready", 32'(s_in_ready), 32'd0);
        check("bp_data",  32'(s_out_data), 32'h00B0);
        s_out_ready = 1'b1;
        step();
        check("bp_second", 32'(s_out_data), 32'h00B1);
        step();
        check("bp_empty_valid", 32'(s_out_valid), 32'd0);
        check("bp_empty_data",  32'(s_out_data),  32'd0);

        // Flush from FULL with a beat offered in the same cycle.
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 16'h00C0;
        step();
        s_in_data   = 16'h00C1;
        step();
        check("fl_full", 32'(s_occ), 32'd2);
        flush     = 1'b1;
        s_in_data = 16'h00C2;
        step();
        flush      = 1'b0;
        s_in_valid = 1'b0;
        check("fl_valid", 32'(s_out_valid), 32'd0);
        check("fl_occ",   32'(s_occ),       32'd0);
        check("fl_data",  32'(s_out_data),  32'd0);
        s_out_ready = 1'b1;
        step();
        check("fl_no_c2", 32'(s_out_valid), 32'd0);

        // Single-register variant: stall then back-to-back replace.
        n_out_ready = 1'b0;
        n_in_valid  = 1'b1;
        n_in_data   = 16'h00D0;
        step();
        n_in_data   = 16'h00D1;
        #1;
        check("ns_stall_ready", 32'(n_in_ready), 32'd0);
        step();
        check("ns_hold_data", 32'(n_out_data), 32'h00D0);
        n_out_ready = 1'b1;
        #1;
        check("ns_open_ready", 32'(n_in_ready), 32'd1);
        step();
        n_in_valid = 1'b0;
        check("ns_d1_data",  32'(n_out_data),  32'h00D1);
        check("ns_d1_valid", 32'(n_out_valid), 32'd1);
        step();
        check("ns_drain", 32'(n_out_valid), 32'd0);

        // Random traffic on both instances; models check every cycle.
        for (int c = 0; c < 10000; c++) begin
            flush = ($urandom_range(0, 31) == 0);
            if (!(s_in_valid && !s_last_push)) begin
                s_in_valid = 1'($urandom_range(0, 1));
                s_in_data  = 16'($urandom);
            end
            if (!(n_in_valid && !n_last_push)) begin
                n_in_valid = 1'($urandom_range(0, 1));
                n_in_data  = 16'($urandom);
            end
            s_out_ready = ($urandom_range(0, 3) != 0);
            n_out_ready = ($urandom_range(0, 3) != 0);
            step();
            check("rand_occ_max", 32'(s_occ <= 2'd2), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipe_stage_reg
